timer_irq: RTL and testbench

//  Memory-mapped 32-bit reload timer and sole interrupt source for the single-cycle MIPS core.

---
 rtl/timer_irq.sv | 163 ++++++++++++++++
 tb/tb_timer_irq.sv | 303 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/timer_irq.sv
// ---------------------------------------------------------------------------
// timer_irq
//   Memory-mapped 32-bit reload timer for the single-cycle MIPS core. It is
//   also the core's only interrupt source. It sits on the data bus next to
//   DataMem and decodes a 16-byte window at BASE_ADDR:
//     +0  TH    reload value loaded into TL on wrap
//     +4  TL    counter, increments once per tick while enabled
//     +8  TCON  [0] enable, [1] irq_en, [2] status (sticky wrap flag)
//     +C  PRE   prescale divisor (TIMER_PRESCALE_EN builds only, else reads 0)
//
//   Optional feature macro: TIMER_PRESCALE_EN
//     defined   -> PRE register plus prescale counter gate the count tick
//     undefined -> tick every cycle, +C reads 0 and ignores writes
//
// Ports
//   clk        system clock, all state updates on posedge
//   reset      synchronous active-high reset
//   addr       data address (ALU result); addr[1:0] ignored
//   wdata      store data
//   MemRd      load strobe; rdata is valid in the same cycle
//   MemWr      store strobe; the write lands on the next posedge
//   pc_kernel  PC[31]; high masks IRQ while the core runs in supervisor mode
//   rdata      read data, zero unless this window is being loaded
//   IRQ        interrupt request to control
// ---------------------------------------------------------------------------
module timer_irq #(
    parameter logic [31:0] BASE_ADDR  = 32'h4000_0000,
    parameter int          PRESCALE_W = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    input  logic        MemRd,
    input  logic        MemWr,
    input  logic        pc_kernel,
    output logic [31:0] rdata,
    output logic        IRQ
);

    localparam logic [1:0] SEL_TH   = 2'd0;
    localparam logic [1:0] SEL_TL   = 2'd1;
    localparam logic [1:0] SEL_TCON = 2'd2;
    localparam logic [1:0] SEL_PRE  = 2'd3;

    // ------------------------------------------------------------------
    // Address decode
    // ------------------------------------------------------------------
    logic       hit;
    logic [1:0] sel;
    logic       wr_th, wr_tl, wr_tcon;
    logic       unused_addr_lsb;

    assign hit     = (addr[31:4] == BASE_ADDR[31:4]);
    assign sel     = addr[3:2];
    assign wr_th   = hit & MemWr & (sel == SEL_TH);
    assign wr_tl   = hit & MemWr & (sel == SEL_TL);
    assign wr_tcon = hit & MemWr & (sel == SEL_TCON);

    // Byte offset within a word has no meaning here.
    assign unused_addr_lsb = ^addr[1:0];

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------
    logic [31:0]           th;
    logic [31:0]           tl;
    logic [2:0]            tcon;
    logic [PRESCALE_W-1:0] pre;
    logic                  tick;
    logic                  step;
    logic                  wrap;

    // step: TL advances this cycle. wrap: this advance is the all-ones
    // rollover, which reloads from TH and raises status.
    assign step = tcon[0] & tick;
    assign wrap = step & (tl == 32'hFFFF_FFFF);

`ifdef TIMER_PRESCALE_EN
    logic                  wr_pre;
    logic [PRESCALE_W-1:0] pcnt;

    assign wr_pre = hit & MemWr & (sel == SEL_PRE);

    // pcnt counts 0..PRE and ticks on the terminal value, so PRE=N divides
    // the count rate by N+1 and PRE=0 ticks every cycle.
    assign tick = (pcnt == pre);

    always_ff @(posedge clk) begin
        if (reset) begin
            pre  <= '0;
            pcnt <= '0;
        end else begin
            if (wr_pre) begin
                pre <= wdata[PRESCALE_W-1:0];
            end
            // Reprogramming the divisor restarts the current period.
            if (wr_pre) begin
                pcnt <= '0;
            end else if (tcon[0]) begin
                pcnt <= tick ? '0 : pcnt + PRESCALE_W'(1);
            end
        end
    end
`else
    // No prescaler: count every enabled cycle, +C is a hole reading 0.
    assign tick = 1'b1;
    assign pre  = '0;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            th <= 32'h0;
        end else if (wr_th) begin
            th <= wdata;
        end
    end

    // A CPU store to TL beats both the increment and the reload. A reload
    // in the same cycle as a TH store uses the old TH (registered value).
    always_ff @(posedge clk) begin
        if (reset) begin
            tl <= 32'h0;
        end else if (wr_tl) begin
            tl <= wdata;
        end else if (wrap) begin
            tl <= th;
        end else if (step) begin
            tl <= tl + 32'd1;
        end
    end

    // A TCON store replaces all three bits, so an acknowledge in the wrap
    // cycle swallows that wrap's status event.
    always_ff @(posedge clk) begin
        if (reset) begin
            tcon <= 3'b000;
        end else if (wr_tcon) begin
            tcon <= wdata[2:0];
        end else if (wrap) begin
            tcon[2] <= 1'b1;
        end
    end

    // ------------------------------------------------------------------
    // Read mux, zero when not addressed so the top level can OR/mux freely
    // ------------------------------------------------------------------
    always_comb begin
        rdata = 32'h0;
        if (hit && MemRd) begin
            case (sel)
                SEL_TH:   rdata = th;
                SEL_TL:   rdata = tl;
                SEL_TCON: rdata = {29'b0, tcon};
                default:  rdata = 32'(pre);
            endcase
        end
    end

    // Level interrupt: held until software clears irq_en or status.
    assign IRQ = tcon[1] & tcon[2] & ~pc_kernel;

endmodule

// File: tb/tb_timer_irq.sv
module tb_timer_irq;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [31:0] addr = '0;
    logic [31:0] wdata = '0;
    logic        MemRd = 1'b0;
    logic        MemWr = 1'b0;
    logic        pc_kernel = 1'b0;
    logic [31:0] rdata;
    logic        IRQ;

    always #5 clk = ~clk;

    timer_irq dut (
        .clk(clk), .reset(reset), .addr(addr), .wdata(wdata),
        .MemRd(MemRd), .MemWr(MemWr), .pc_kernel(pc_kernel),
        .rdata(rdata), .IRQ(IRQ)
    );

    localparam logic [31:0] B      = 32'h4000_0000;
    localparam logic [31:0] A_TH   = B;
    localparam logic [31:0] A_TL   = B + 32'd4;
    localparam logic [31:0] A_TCON = B + 32'd8;
    localparam logic [31:0] A_PRE  = B + 32'd12;

    int n_tests = 0;
    int n_fail  = 0;

    // ------------------------------------------------------------------
    // Reference model: register file view of the timer, advanced once per
    // clock from the bench's own bus stimulus.
    // ------------------------------------------------------------------
    logic [31:0] m_th = '0, m_tl = '0, m_pre = '0, m_pcnt = '0;
    logic [2:0]  m_tcon = '0;

    always @(posedge clk) begin : model
        logic        w, tick, step;
        logic [32:0] inc;
        logic [31:0] n_th, n_tl, n_pre, n_pcnt;
        logic [2:0]  n_tcon;
        w      = MemWr && (addr[31:4] == B[31:4]);
        n_th   = m_th;
        n_tl   = m_tl;
        n_tcon = m_tcon;
        n_pre  = m_pre;
        n_pcnt = m_pcnt;
`ifdef TIMER_PRESCALE_EN
        tick = (m_pcnt == m_pre);
`else
        tick = 1'b1;
`endif
        step = m_tcon[0] && tick;
        inc  = {1'b0, m_tl} + 33'd1;
        if (step) begin
            if (inc[32]) begin
                n_tl      = m_th;
                n_tcon[2] = 1'b1;
            end else begin
                n_tl = inc[31:0];
            end
        end
        if (m_tcon[0]) n_pcnt = tick ? 32'd0 : m_pcnt + 32'd1;
        if (w) begin
            case (addr[3:2])
                2'd0: n_th   = wdata;
                2'd1: n_tl   = wdata;
                2'd2: n_tcon = wdata[2:0];
                default: begin
`ifdef TIMER_PRESCALE_EN
                    n_pre  = wdata & 32'h0000_FFFF;
                    n_pcnt = 32'd0;
`endif
                end
            endcase
        end
        if (reset) begin
            n_th = 0; n_tl = 0; n_tcon = 0; n_pre = 0; n_pcnt = 0;
        end
        m_th   <= n_th;
        m_tl   <= n_tl;
        m_tcon <= n_tcon;
        m_pre  <= n_pre;
        m_pcnt <= n_pcnt;
    end

    function automatic logic [31:0] m_rdata();
        if (!(MemRd && addr[31:4] == B[31:4])) return 32'h0;
        case (addr[3:2])
            2'd0:    return m_th;
            2'd1:    return m_tl;
            2'd2:    return {29'b0, m_tcon};
            default: return m_pre;
        endcase
    endfunction

    // ------------------------------------------------------------------
    // Helpers. Ops start at posedge+1; reads sample 1ns after driving.
    // ------------------------------------------------------------------
    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic idle();
        addr = '0; wdata = '0; MemRd = 1'b0; MemWr = 1'b0;
    endtask

    task automatic cyc(input int n);
        repeat (n) begin @(posedge clk); #1; end
    endtask

    task automatic wr(input logic [31:0] a, input logic [31:0] d);
        addr = a; wdata = d; MemWr = 1'b1;
        @(posedge clk); #1;
        idle();
    endtask

    task automatic rd_chk(input string name, input logic [31:0] a, input logic [31:0] exp);
        addr = a; MemRd = 1'b1;
        #1;
        chk(name, rdata, exp);
        idle();
    endtask

    task automatic do_reset(input int n);
        idle();
        reset = 1'b1;
        cyc(n);
        reset = 1'b0;
    endtask

    // ------------------------------------------------------------------
    // Directed table: writes apply d, reads expect d
    // ------------------------------------------------------------------
    typedef struct {
        bit          is_wr;
        logic [31:0] a;
        logic [31:0] d;
        string       name;
    } op_t;

    op_t tbl[$];

    function automatic op_t mk(input bit w, input logic [31:0] a, input logic [31:0] d, input string n);
        op_t o;
        o.is_wr = w; o.a = a; o.d = d; o.name = n;
        return o;
    endfunction

    logic [31:0] pre_exp;

    initial begin
`ifdef TIMER_PRESCALE_EN
        pre_exp = 32'd7;
`else
        pre_exp = 32'd0;
`endif
        tbl.push_back(mk(0, A_TH,   32'h0,         "rst_th"));
        tbl.push_back(mk(0, A_TL,   32'h0,         "rst_tl"));
        tbl.push_back(mk(0, A_TCON, 32'h0,         "rst_tcon"));
        tbl.push_back(mk(0, A_PRE,  32'h0,         "rst_pre"));
        tbl.push_back(mk(1, A_TH,   32'h1234_5678, ""));
        tbl.push_back(mk(0, A_TH,   32'h1234_5678, "th_rw"));
        tbl.push_back(mk(0, B + 3,  32'h1234_5678, "lsb_ignored"));
        tbl.push_back(mk(1, A_TL,   32'hCAFE_0001, ""));
        tbl.push_back(mk(0, A_TL,   32'hCAFE_0001, "tl_rw_frozen"));
        tbl.push_back(mk(1, A_TCON, 32'hFFFF_FFFC, ""));
        tbl.push_back(mk(0, A_TCON, 32'h0000_0004, "tcon_3bit"));
        tbl.push_back(mk(1, A_TCON, 32'h0,         ""));
        tbl.push_back(mk(1, B + 32'h10, 32'hDEAD_BEEF, ""));
        tbl.push_back(mk(1, 32'h4,  32'h1111_1111, ""));
        tbl.push_back(mk(0, A_TH,   32'h1234_5678, "miss_wr_th"));
        tbl.push_back(mk(0, A_TL,   32'hCAFE_0001, "miss_wr_tl"));
        tbl.push_back(mk(0, B + 32'h10, 32'h0,     "miss_rd_10"));
        tbl.push_back(mk(0, 32'h4,  32'h0,         "miss_rd_04"));
        tbl.push_back(mk(1, A_PRE,  32'h7,         ""));
        tbl.push_back(mk(0, A_PRE,  pre_exp,       "pre_rw"));

        // 1. reset
        do_reset(2);
        chk("rst_irq", {31'b0, IRQ}, 32'h0);
        for (int i = 0; i < tbl.size(); i++) begin
            if (tbl[i].is_wr) wr(tbl[i].a, tbl[i].d);
            else begin
                rd_chk(tbl[i].name, tbl[i].a, tbl[i].d);
                cyc(1);
            end
        end
        // hit without MemRd must not drive the bus
        addr = A_TH; #1;
        chk("no_memrd", rdata, 32'h0);
        idle();
        cyc(1);

        // 2. overflow / reload
        do_reset(1);
        wr(A_TH, 32'hFFFF_FFF0);
        wr(A_TL, 32'hFFFF_FFFE);
        wr(A_TCON, 32'h3);
        cyc(2);
        rd_chk("ovf_tl", A_TL, 32'hFFFF_FFF0);
        rd_chk("ovf_tcon", A_TCON, 32'h7);
        chk("ovf_irq", {31'b0, IRQ}, 32'h1);

        // 3. kernel mask and acknowledge
        pc_kernel = 1'b1; #1;
        chk("kmask_irq", {31'b0, IRQ}, 32'h0);
        pc_kernel = 1'b0; #1;
        chk("kunmask_irq", {31'b0, IRQ}, 32'h1);
        wr(A_TCON, 32'h3);
        chk("ack_irq", {31'b0, IRQ}, 32'h0);
        wr(A_TCON, 32'h6);
        chk("sw_status_irq", {31'b0, IRQ}, 32'h1);
        wr(A_TCON, 32'h4);
        chk("irqen_off_irq", {31'b0, IRQ}, 32'h0);

        // 4. collisions in the wrap cycle
        do_reset(1);
        wr(A_TH, 32'hFFFF_FFF0);
        wr(A_TL, 32'hFFFF_FFFF);
        wr(A_TCON, 32'h1);
        wr(A_TL, 32'h5);
        rd_chk("col_tl_wr", A_TL, 32'h5);
        rd_chk("col_tl_status", A_TCON, 32'h5);

        do_reset(1);
        wr(A_TH, 32'h0000_1234);
        wr(A_TL, 32'hFFFF_FFFF);
        wr(A_TCON, 32'h1);
        wr(A_TCON, 32'h1);
        rd_chk("col_tcon_ack", A_TCON, 32'h1);
        rd_chk("col_tcon_reload", A_TL, 32'h0000_1234);

        do_reset(1);
        wr(A_TH, 32'hAAAA_0000);
        wr(A_TL, 32'hFFFF_FFFF);
        wr(A_TCON, 32'h1);
        wr(A_TH, 32'hBBBB_0000);
        rd_chk("col_th_oldreload", A_TL, 32'hAAAA_0000);
        rd_chk("col_th_new", A_TH, 32'hBBBB_0000);
        rd_chk("col_th_status", A_TCON, 32'h5);

        // reset mid-count overrides a simultaneous store
        wr(A_TCON, 32'h7);
        chk("pre_rst_irq", {31'b0, IRQ}, 32'h1);
        reset = 1'b1; addr = A_TH; wdata = 32'hFFFF; MemWr = 1'b1;
        @(posedge clk); #1;
        chk("rst_mid_irq", {31'b0, IRQ}, 32'h0);
        reset = 1'b0; idle();
        rd_chk("rst_mid_th", A_TH, 32'h0);
        rd_chk("rst_mid_tcon", A_TCON, 32'h0);
        cyc(1);

`ifdef TIMER_PRESCALE_EN
        // 5. prescale: PRE=3 -> one increment per 4 enabled cycles
        do_reset(1);
        wr(A_PRE, 32'h3);
        wr(A_TCON, 32'h1);
        cyc(3);
        rd_chk("pre_tl_e3", A_TL, 32'h0);
        cyc(1);
        rd_chk("pre_tl_e4", A_TL, 32'h1);
        cyc(4);
        rd_chk("pre_tl_e8", A_TL, 32'h2);
`endif

        // Randomized traffic against the model
        do_reset(1);
        for (int i = 0; i < 4000; i++) begin
            int s;
            s = $urandom_range(0, 3);
            reset     = ($urandom_range(0, 199) == 0);
            pc_kernel = ($urandom_range(0, 3) == 0);
            MemWr     = ($urandom_range(0, 3) == 0);
            MemRd     = $urandom_range(0, 1);
            case ($urandom_range(0, 7))
                6:       addr = B + 32'h10 + 32'($urandom_range(0, 255));
                7:       addr = $urandom;
                default: addr = B + 32'(s * 4) + 32'($urandom_range(0, 3));
            endcase
            case (s)
                0: wdata = ($urandom_range(0, 1) == 1) ? $urandom : 32'hFFFF_FFF0 | 32'($urandom_range(0, 15));
                1: wdata = 32'hFFFF_FFF0 | 32'($urandom_range(0, 15));
                2: wdata = $urandom | (($urandom_range(0, 3) != 0) ? 32'h1 : 32'h0);
                default: wdata = 32'($urandom_range(0, 3)) | ($urandom & 32'hFFFF_0000);
            endcase
            #1;
            chk("rand_rdata", rdata, m_rdata());
            chk("rand_irq", {31'b0, IRQ}, {31'b0, m_tcon[1] & m_tcon[2] & ~pc_kernel});
            @(posedge clk); #1;
        end
        reset = 1'b0;
        idle();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
